// File: rtl/huff_pair_decoder.sv
// rtl/huff_pair_decoder.sv - bit-serial MP3 big-values Huffman pair decoder using an external codebook ROM
// Optional codeword-overflow resync and err output are enabled by defining HUFF_OVERFLOW_CHECK_EN.
module huff_pair_decoder #(
  parameter int MAX_BITS    = 19,
  parameter int MAX_LINBITS = 13,
  parameter int OUT_W       = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    axiiv,
  input  logic                    axiid,
  output logic                    axiir,
  input  logic [3:0]              linbits,
  output logic [MAX_BITS-1:0]     lut_code,
  output logic [4:0]              lut_len,
  input  logic                    lut_hit,
  input  logic [3:0]              lut_x,
  input  logic [3:0]              lut_y,
  output logic                    axiov,
  input  logic                    axior,
  output logic signed [OUT_W-1:0] x_val,
  output logic signed [OUT_W-1:0] y_val,
  output logic [5:0]              pair_bits
`ifdef HUFF_OVERFLOW_CHECK_EN
  ,
  output logic                    err
`endif
);

  typedef enum logic [2:0] {CODE, XLIN, XSGN, YLIN, YSGN, OUT} state_t;

  localparam logic [4:0] FULL_LEN = 5'(MAX_BITS);
  localparam logic [3:0] MAX_LB   = 4'(MAX_LINBITS);

  state_t                   state_q, state_d;
  logic [MAX_BITS-1:0]      code_q, code_d;
  logic [4:0]               len_q, len_d;
  logic [3:0]               lb_q, lb_d;
  logic [3:0]               xabs_q, xabs_d;
  logic [3:0]               yabs_q, yabs_d;
  logic [3:0]               cnt_q, cnt_d;
  logic [MAX_LINBITS-1:0]   xlin_q, xlin_d;
  logic [MAX_LINBITS-1:0]   ylin_q, ylin_d;
  logic                     xsgn_q, xsgn_d;
  logic                     ysgn_q, ysgn_d;
  logic [5:0]               pbits_q, pbits_d;
  logic signed [OUT_W-1:0]  xval_q, xval_d;
  logic signed [OUT_W-1:0]  yval_q, yval_d;
  logic                     hit, full, take;
`ifdef HUFF_OVERFLOW_CHECK_EN
  logic                     err_q, err_d;
`endif

  function automatic logic escaped(input logic [3:0] a, input logic [3:0] lb);
    return (a == 4'd15) && (lb != 4'd0);
  endfunction

  function automatic state_t after_x(input logic [3:0] ya, input logic [3:0] lb);
    if (escaped(ya, lb))   return YLIN;
    else if (ya != 4'd0)   return YSGN;
    else                   return OUT;
  endfunction

  function automatic logic signed [OUT_W-1:0] comp_val(input logic [3:0] a,
                                                       input logic [MAX_LINBITS-1:0] l,
                                                       input logic s);
    logic [OUT_W-1:0] m;
    m = OUT_W'(a) + OUT_W'(l);
    return s ? -m : m;
  endfunction

  assign hit  = (len_q != 5'd0) && lut_hit;
  assign full = (len_q == FULL_LEN);
  assign take = axiiv && axiir;

  always_comb begin
    axiir = 1'b0;
    axiov = 1'b0;
    case (state_q)
      CODE:                   axiir = !hit && !full;
      XLIN, XSGN, YLIN, YSGN: axiir = 1'b1;
      OUT:                    axiov = 1'b1;
      default:                axiir = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    len_d   = len_q;
    lb_d    = lb_q;
    xabs_d  = xabs_q;
    yabs_d  = yabs_q;
    cnt_d   = cnt_q;
    xlin_d  = xlin_q;
    ylin_d  = ylin_q;
    xsgn_d  = xsgn_q;
    ysgn_d  = ysgn_q;
    pbits_d = pbits_q;
    xval_d  = xval_q;
    yval_d  = yval_q;
`ifdef HUFF_OVERFLOW_CHECK_EN
    err_d   = 1'b0;
`endif
    case (state_q)
      CODE: begin
        if (len_q == 5'd0)
          lb_d = (linbits > MAX_LB) ? MAX_LB : linbits;
        if (hit) begin
          // Decode cycle consumes no bit; abs values come straight from the ROM.
          xabs_d = lut_x;
          yabs_d = lut_y;
          if (escaped(lut_x, lb_q))  state_d = XLIN;
          else if (lut_x != 4'd0)    state_d = XSGN;
          else                       state_d = after_x(lut_y, lb_q);
        end else if (full) begin
`ifdef HUFF_OVERFLOW_CHECK_EN
          err_d   = 1'b1;
          len_d   = 5'd0;
          code_d  = '0;
          pbits_d = 6'd0;
`endif
        end else if (take) begin
          code_d  = {code_q[MAX_BITS-2:0], axiid};
          len_d   = len_q + 5'd1;
          pbits_d = pbits_q + 6'd1;
        end
      end
      XLIN: if (take) begin
        xlin_d  = {xlin_q[MAX_LINBITS-2:0], axiid};
        pbits_d = pbits_q + 6'd1;
        cnt_d   = cnt_q + 4'd1;
        if (cnt_q == lb_q - 4'd1) begin
          cnt_d   = 4'd0;
          state_d = XSGN;
        end
      end
      XSGN: if (take) begin
        xsgn_d  = axiid;
        pbits_d = pbits_q + 6'd1;
        state_d = after_x(yabs_q, lb_q);
      end
      YLIN: if (take) begin
        ylin_d  = {ylin_q[MAX_LINBITS-2:0], axiid};
        pbits_d = pbits_q + 6'd1;
        cnt_d   = cnt_q + 4'd1;
        if (cnt_q == lb_q - 4'd1) begin
          cnt_d   = 4'd0;
          state_d = YSGN;
        end
      end
      YSGN: if (take) begin
        ysgn_d  = axiid;
        pbits_d = pbits_q + 6'd1;
        state_d = OUT;
      end
      OUT: if (axior) begin
        state_d = CODE;
        len_d   = 5'd0;
        code_d  = '0;
        xlin_d  = '0;
        ylin_d  = '0;
        xsgn_d  = 1'b0;
        ysgn_d  = 1'b0;
        cnt_d   = 4'd0;
        pbits_d = 6'd0;
      end
      default: state_d = CODE;
    endcase
    // Values are formed from next-state fields so the final sign bit is included.
    if (state_d == OUT && state_q != OUT) begin
      xval_d = comp_val(xabs_d, xlin_d, xsgn_d);
      yval_d = comp_val(yabs_d, ylin_d, ysgn_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CODE;
      code_q  <= '0;
      len_q   <= 5'd0;
      lb_q    <= 4'd0;
      xabs_q  <= 4'd0;
      yabs_q  <= 4'd0;
      cnt_q   <= 4'd0;
      xlin_q  <= '0;
      ylin_q  <= '0;
      xsgn_q  <= 1'b0;
      ysgn_q  <= 1'b0;
      pbits_q <= 6'd0;
      xval_q  <= '0;
      yval_q  <= '0;
`ifdef HUFF_OVERFLOW_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      len_q   <= len_d;
      lb_q    <= lb_d;
      xabs_q  <= xabs_d;
      yabs_q  <= yabs_d;
      cnt_q   <= cnt_d;
      xlin_q  <= xlin_d;
      ylin_q  <= ylin_d;
      xsgn_q  <= xsgn_d;
      ysgn_q  <= ysgn_d;
      pbits_q <= pbits_d;
      xval_q  <= xval_d;
      yval_q  <= yval_d;
`ifdef HUFF_OVERFLOW_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign lut_code  = code_q;
  assign lut_len   = len_q;
  assign x_val     = xval_q;
  assign y_val     = yval_q;
  assign pair_bits = pbits_q;
`ifdef HUFF_OVERFLOW_CHECK_EN
  assign err       = err_q;
`endif

endmodule

// File: tb/tb_huff_pair_decoder.sv
// tb/tb_huff_pair_decoder.sv - directed self-checking bench for huff_pair_decoder
module tb_huff_pair_decoder;

  logic               clk = 1'b0;
  logic               rst;
  logic               axiiv, axiid, axiir;
  logic [3:0]         linbits;
  logic [18:0]        lut_code;
  logic [4:0]         lut_len;
  logic               lut_hit;
  logic [3:0]         lut_x, lut_y;
  logic               axiov, axior;
  logic signed [15:0] x_val, y_val;
  logic [5:0]         pair_bits;
`ifdef HUFF_OVERFLOW_CHECK_EN
  logic               err;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int rom_sel = 0;

  always #5 clk = ~clk;

  huff_pair_decoder dut (
    .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid), .axiir(axiir),
    .linbits(linbits), .lut_code(lut_code), .lut_len(lut_len), .lut_hit(lut_hit),
    .lut_x(lut_x), .lut_y(lut_y), .axiov(axiov), .axior(axior),
    .x_val(x_val), .y_val(y_val), .pair_bits(pair_bits)
`ifdef HUFF_OVERFLOW_CHECK_EN
    , .err(err)
`endif
  );

  // Codebook: 0 = MP3 table 1, 1 = "11" -> (15,2), 2 = no codeword ever hits.
  always_comb begin
    lut_hit = 1'b0;
    lut_x   = 4'd0;
    lut_y   = 4'd0;
    if (rom_sel == 0) begin
      if (lut_len == 5'd1 && lut_code[0] == 1'b1) lut_hit = 1'b1;
      else if (lut_len == 5'd2 && lut_code[1:0] == 2'b01) begin lut_hit = 1'b1; lut_x = 4'd1; end
      else if (lut_len == 5'd3 && lut_code[2:0] == 3'b001) begin lut_hit = 1'b1; lut_y = 4'd1; end
      else if (lut_len == 5'd3 && lut_code[2:0] == 3'b000) begin lut_hit = 1'b1; lut_x = 4'd1; lut_y = 4'd1; end
    end else if (rom_sel == 1) begin
      if (lut_len == 5'd2 && lut_code[1:0] == 2'b11) begin lut_hit = 1'b1; lut_x = 4'd15; lut_y = 4'd2; end
    end
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      axiiv = 1'b1;
      axiid = b;
      if (axiir) begin
        @(posedge clk);
        ok = 1'b1;
      end
    end
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic wait_out(input string tag, input int ex, input int ey, input int epb);
    logic got;
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      axiiv = 1'b0;
      if (axiov) got = 1'b1;
    end
    chk({tag, "_valid"}, got, 1);
    if (got) begin
      chk({tag, "_x"}, x_val, ex);
      chk({tag, "_y"}, y_val, ey);
      chk({tag, "_bits"}, pair_bits, epb);
      axior = 1'b1;
      @(posedge clk);
      @(negedge clk);
      axior = 1'b0;
      chk({tag, "_done"}, axiov, 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    axiiv = 1'b0;
    @(negedge clk);
    rst   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; axiiv = 1'b0; axiid = 1'b0; axior = 1'b0; linbits = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_len", lut_len, 0);
    chk("rst_code", lut_code, 0);
    chk("rst_axiov", axiov, 0);
    chk("rst_x", x_val, 0);
    chk("rst_bits", pair_bits, 0);
    chk("rst_axiir", axiir, 1);

    // "1" -> (0,0): one bubble cycle then valid
    send_bit(1'b1);
    @(negedge clk);
    axiiv = 1'b0;
    chk("t1_bubble_axiir", axiir, 0);
    chk("t1_bubble_axiov", axiov, 0);
    @(negedge clk);
    chk("t1_latency", axiov, 1);
    wait_out("t1", 0, 0, 1);

    send_bits(32'b01, 2); send_bit(1'b1);
    wait_out("t2", -1, 0, 3);

    send_bits(32'b000, 3); send_bit(1'b0); send_bit(1'b1);
    wait_out("t3", 1, -1, 5);

    // Escape: x = 15 + 4'b1010 = 25, negative
    rom_sel = 1; linbits = 4'd4;
    send_bits(32'b11, 2); send_bits(32'b1010, 4); send_bit(1'b1); send_bit(1'b0);
    wait_out("t4", -25, 2, 8);

    // linbits=0 disables escape even with abs 15
    linbits = 4'd0;
    send_bits(32'b11, 2); send_bit(1'b0); send_bit(1'b0);
    wait_out("t5", 15, 2, 4);

    // linbits=15 clamps to 13: x = 15 + 8191
    linbits = 4'd15;
    send_bits(32'b11, 2); send_bits(32'h1fff, 13); send_bit(1'b0); send_bit(1'b1);
    wait_out("t6", 8206, -2, 17);

    // Backpressure in OUT
    rom_sel = 0; linbits = 4'd0;
    send_bit(1'b1);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      axiiv = 1'b1;
      axiid = 1'b1;
      chk("bp_axiir", axiir, 0);
      chk("bp_axiov", axiov, 1);
      chk("bp_len", lut_len, 1);
    end
    wait_out("bp", 0, 0, 1);
    send_bits(32'b01, 2); send_bit(1'b0);
    wait_out("bp_next", 1, 0, 3);

    // Reset mid-codeword
    send_bits(32'b00, 2);
    do_reset();
    chk("mid_rst_len", lut_len, 0);
    chk("mid_rst_axiov", axiov, 0);
    chk("mid_rst_bits", pair_bits, 0);
    send_bit(1'b1);
    wait_out("after_rst", 0, 0, 1);

    // Codeword overflow
    rom_sel = 2;
    send_bits(32'h0, 19);
`ifdef HUFF_OVERFLOW_CHECK_EN
    @(negedge clk);
    axiiv = 1'b0;
    chk("ovf_err_pre", err, 0);
    chk("ovf_len_full", lut_len, 19);
    @(negedge clk);
    chk("ovf_err_pulse", err, 1);
    chk("ovf_len_clr", lut_len, 0);
    @(negedge clk);
    chk("ovf_err_drop", err, 0);
    chk("ovf_axiov", axiov, 0);
`else
    @(negedge clk);
    axiiv = 1'b1;
    axiid = 1'b0;
    chk("ovf_axiir", axiir, 0);
    chk("ovf_len", lut_len, 19);
    repeat (3) @(negedge clk);
    chk("ovf_stall_len", lut_len, 19);
    chk("ovf_axiov", axiov, 0);
    do_reset();
`endif
    rom_sel = 0;
    send_bit(1'b1);
    wait_out("resync", 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
